// File: rtl/pi_request_queue.sv
// Pi register-write decoder and request FIFO feeding the 68k access engine.
// Tracks one in-flight request, captures read results and drives busy.
module pi_request_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       nRESET,
  input  logic                       pi_wr_stb,
  input  logic [2:0]                 pi_addr,
  input  logic [15:0]                pi_wdata,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [23:0]                req_address,
  output logic [1:0]                 req_size,
  output logic                       req_read,
  output logic [2:0]                 req_fc,
  output logic [31:0]                req_data,
  input  logic                       done_stb,
  input  logic [31:0]                done_rdata,
  output logic [31:0]                rd_data,
  output logic                       busy,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        rd;
    logic [2:0]  fc;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          inflight_q, inflight_d;
  logic          ovf_q, ovf_d;
  logic          pend_rd_q, pend_rd_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   stage_data_q, stage_data_d;
  logic [15:0]   stage_lo_q, stage_lo_d;

  entry_t head;
  entry_t new_ent;
  logic   not_empty;
  logic   pop;
  logic   commit;
  logic   push;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign head      = not_empty ? mem_q[rd_ptr_q] : '0;
  assign req_valid = not_empty & ~inflight_q;
  assign pop       = req_valid & req_ready;
  assign commit    = pi_wr_stb & (pi_addr == 3'd3);
  // A full queue still accepts a commit when the head leaves this cycle.
  assign push      = commit & (~full | pop);

  assign new_ent.addr = {pi_wdata[7:0], stage_lo_q};
  assign new_ent.size = pi_wdata[9:8];
  assign new_ent.rd   = pi_wdata[10];
  assign new_ent.fc   = pi_wdata[13:11];
  assign new_ent.data = stage_data_q;

  assign req_address = head.addr;
  assign req_size    = head.size;
  assign req_read    = head.rd;
  assign req_fc      = head.fc;
  assign req_data    = head.data;
  assign rd_data     = rd_data_q;
  assign busy        = not_empty | inflight_q;
  assign overflow    = ovf_q;
  assign level       = level_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    inflight_d   = inflight_q;
    ovf_d        = ovf_q;
    pend_rd_d    = pend_rd_q;
    rd_data_d    = rd_data_q;
    stage_data_d = stage_data_q;
    stage_lo_d   = stage_lo_q;

    if (pi_wr_stb) begin
      case (pi_addr)
        3'd0: stage_data_d[15:0]  = pi_wdata;
        3'd1: stage_data_d[31:16] = pi_wdata;
        3'd2: stage_lo_d          = pi_wdata;
        3'd3: if (!push) ovf_d    = 1'b1;
        3'd5: ovf_d               = 1'b0;
        default: ;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = new_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      inflight_d = 1'b1;
      pend_rd_d  = head.rd;
    end else if (done_stb && inflight_q) begin
      inflight_d = 1'b0;
      if (pend_rd_q) rd_data_d = done_rdata;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      inflight_q   <= 1'b0;
      ovf_q        <= 1'b0;
      pend_rd_q    <= 1'b0;
      rd_data_q    <= '0;
      stage_data_q <= '0;
      stage_lo_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      inflight_q   <= inflight_d;
      ovf_q        <= ovf_d;
      pend_rd_q    <= pend_rd_d;
      rd_data_q    <= rd_data_d;
      stage_data_q <= stage_data_d;
      stage_lo_q   <= stage_lo_d;
    end
  end

endmodule

// File: tb/tb_pi_request_queue.sv
// Bench for pi_request_queue: queue-based reference model plus a
// scoreboard monitor that checks each handshake and the status outputs.
module tb_pi_request_queue;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          sys_clk = 0;
  logic          nRESET = 0;
  logic          pi_wr_stb = 0;
  logic [2:0]    pi_addr = 0;
  logic [15:0]   pi_wdata = 0;
  logic          req_valid;
  logic          req_ready = 0;
  logic [23:0]   req_address;
  logic [1:0]    req_size;
  logic          req_read;
  logic [2:0]    req_fc;
  logic [31:0]   req_data;
  logic          done_stb = 0;
  logic [31:0]   done_rdata = 0;
  logic [31:0]   rd_data;
  logic          busy;
  logic          full;
  logic          overflow;
  logic [LW-1:0] level;

  pi_request_queue #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .nRESET(nRESET),
    .pi_wr_stb(pi_wr_stb), .pi_addr(pi_addr), .pi_wdata(pi_wdata),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_size(req_size),
    .req_read(req_read), .req_fc(req_fc), .req_data(req_data),
    .done_stb(done_stb), .done_rdata(done_rdata),
    .rd_data(rd_data), .busy(busy), .full(full),
    .overflow(overflow), .level(level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] a;
    logic [1:0]  s;
    logic        r;
    logic [2:0]  fc;
    logic [31:0] d;
  } ent_t;

  int total = 0;
  int bad = 0;
  int popped = 0;

  ent_t        m_q[$];
  ent_t        sbq[$];
  bit          m_infl = 0;
  bit          m_ovf = 0;
  bit          m_last = 0;
  logic [31:0] m_rd = 0;
  logic [31:0] s_data = 0;
  logic [15:0] s_lo = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of committed requests plus one in-flight slot.
  always @(posedge sys_clk or negedge nRESET) begin
    int   n0;
    bit   pop;
    ent_t e;
    if (!nRESET) begin
      m_q.delete();
      sbq.delete();
      m_infl = 0;
      m_ovf  = 0;
      m_last = 0;
      m_rd   = 0;
      s_data = 0;
      s_lo   = 0;
    end else begin
      n0  = m_q.size();
      pop = (n0 > 0) && !m_infl && req_ready;
      if (pop) begin
        m_last = m_q[0].r;
        void'(m_q.pop_front());
        m_infl = 1;
      end else if (done_stb && m_infl) begin
        m_infl = 0;
        if (m_last) m_rd = done_rdata;
      end
      if (pi_wr_stb) begin
        case (pi_addr)
          3'd0: s_data[15:0] = pi_wdata;
          3'd1: s_data[31:16] = pi_wdata;
          3'd2: s_lo = pi_wdata;
          3'd3: begin
            e.a  = {pi_wdata[7:0], s_lo};
            e.s  = pi_wdata[9:8];
            e.r  = pi_wdata[10];
            e.fc = pi_wdata[13:11];
            e.d  = s_data;
            if (n0 < DEPTH || pop) begin
              m_q.push_back(e);
              sbq.push_back(e);
            end else begin
              m_ovf = 1;
            end
          end
          3'd5: m_ovf = 0;
          default: ;
        endcase
      end
    end
  end

  // Monitor: status every cycle, scoreboard pop on each handshake.
  always @(negedge sys_clk) begin
    ent_t e;
    chk("level", 64'(level), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("busy", 64'(busy), 64'(m_q.size() != 0 || m_infl));
    chk("req_valid", 64'(req_valid), 64'(m_q.size() != 0 && !m_infl));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    if (m_q.size() == 0)
      chk("req_idle_zero",
          64'({req_address, req_size, req_read, req_fc, req_data}), 64'(0));
    if (req_valid && req_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        popped++;
        chk("req_entry",
            64'({req_address, req_size, req_read, req_fc, req_data}),
            64'({e.a, e.s, e.r, e.fc, e.d}));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    pi_addr   = a;
    pi_wdata  = d;
    pi_wr_stb = 1;
    tick();
    pi_wr_stb = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_infl) && n < 300) begin
      req_ready  = 1;
      done_stb   = 1;
      done_rdata = $urandom;
      tick();
      n++;
    end
    req_ready = 0;
    done_stb  = 0;
    chk("drain_bound", 64'(n < 300), 64'(1));
  endtask

  initial begin
    int p0;
    int nc;
    int k;

    repeat (3) tick();
    chk("rst_valid", 64'(req_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_rd", 64'(rd_data), 64'(0));
    nRESET = 1;
    tick();

    // single write request
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'hABCD);
    wr(3'd2, 16'h0004);
    wr(3'd3, 16'h0100);
    chk("t1_valid", 64'(req_valid), 64'(1));
    chk("t1_addr", 64'(req_address), 64'(24'h000004));
    chk("t1_size", 64'(req_size), 64'(2'b01));
    chk("t1_read", 64'(req_read), 64'(0));
    chk("t1_data", 64'(req_data), 64'(32'hABCD1234));
    chk("t1_busy", 64'(busy), 64'(1));
    req_ready = 1;
    tick();
    req_ready = 0;
    tick();
    done_stb   = 1;
    done_rdata = 32'h5555AAAA;
    tick();
    done_stb = 0;
    chk("t1_busy_low", 64'(busy), 64'(0));
    chk("t1_rd_keep", 64'(rd_data), 64'(0));

    // read completion
    wr(3'd3, 16'h0500);
    chk("t2_read", 64'(req_read), 64'(1));
    req_ready = 1;
    tick();
    req_ready  = 0;
    done_stb   = 1;
    done_rdata = 32'hDEADBEEF;
    tick();
    done_stb = 0;
    chk("t2_rd", 64'(rd_data), 64'(32'hDEADBEEF));

    // fill, overflow, clear, then push+pop while full
    req_ready = 0;
    for (int i = 0; i < DEPTH; i++) wr(3'd3, 16'h0100 | 16'(i + 8'h10));
    chk("t3_full", 64'(full), 64'(1));
    chk("t3_level", 64'(level), 64'(DEPTH));
    chk("t3_ovf0", 64'(overflow), 64'(0));
    wr(3'd3, 16'h01EE);
    chk("t3_ovf1", 64'(overflow), 64'(1));
    chk("t3_level2", 64'(level), 64'(DEPTH));
    wr(3'd5, 16'h0000);
    chk("t3_ovf_clr", 64'(overflow), 64'(0));
    req_ready = 1;
    wr(3'd3, 16'h01AA);
    req_ready = 0;
    chk("t5_level", 64'(level), 64'(DEPTH));
    chk("t5_ovf", 64'(overflow), 64'(0));
    drain();

    // ordering across wrap with engine acking every third cycle
    p0 = popped;
    nc = 2 * DEPTH + 3;
    k  = 0;
    for (int c = 0; c < 3 * nc + 12; c++) begin
      req_ready  = (c % 3 == 0);
      done_stb   = (c % 3 == 1);
      done_rdata = $urandom;
      if (c % 3 == 2 && k < nc) begin
        pi_addr   = 3'd3;
        pi_wdata  = 16'h0100 | 16'(k + 8'h40);
        pi_wr_stb = 1;
        k++;
      end else begin
        pi_wr_stb = 0;
      end
      tick();
    end
    pi_wr_stb = 0;
    drain();
    chk("t4_count", 64'(popped - p0), 64'(nc));
    chk("t4_ovf", 64'(overflow), 64'(0));

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      pi_wr_stb  = ($urandom_range(0, 2) == 0);
      pi_addr    = $urandom_range(0, 1) ? 3'd3 : 3'($urandom_range(0, 7));
      pi_wdata   = 16'($urandom);
      req_ready  = ($urandom_range(0, 3) == 0);
      done_stb   = ($urandom_range(0, 2) == 0);
      done_rdata = $urandom;
      tick();
    end
    pi_wr_stb = 0;
    drain();

    // reset while a request is in flight with two queued
    wr(3'd3, 16'h0401);
    wr(3'd3, 16'h0402);
    wr(3'd3, 16'h0403);
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("t6_pre_level", 64'(level), 64'(2));
    #2;
    nRESET = 0;
    #1;
    chk("t6_valid", 64'(req_valid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    tick();
    nRESET     = 1;
    done_stb   = 1;
    done_rdata = 32'hCAFEF00D;
    tick();
    done_stb = 0;
    tick();
    chk("t6_rd", 64'(rd_data), 64'(0));
    chk("t6_busy2", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pi_request_queue.md
# pi_request_queue

Upstream stage of the 68k bus access engine. It decodes synchronized Pi register writes into complete bus requests and holds them in a small FIFO, so the Pi can post several writes without polling. Requests go to the access engine over a valid/ready handshake, one at a time. The block also captures read results and produces the busy flag shown on GPIO3.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- sys_clk  in  1  system clock (PLL output); all logic on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- pi_wr_stb  in  1  one-cycle strobe; Pi write already synchronized and edge-detected.
- pi_addr  in  3  Pi register address, valid with pi_wr_stb.
- pi_wdata  in  16  Pi write data, valid with pi_wr_stb.
- req_valid  out  1  head entry is presented to the access engine.
- req_ready  in  1  access engine accepts the head entry this cycle.
- req_address  out  24  head entry address.
- req_size  out  2  head entry size; bit1 = 32-bit (two cycles), bit0 = word.
- req_read  out  1  head entry direction; 1 = read.
- req_fc  out  3  head entry function code.
- req_data  out  32  head entry write data.
- done_stb  in  1  one-cycle pulse; access engine finished the accepted request.
- done_rdata  in  32  read data, valid with done_stb.
- rd_data  out  32  data of the most recent completed read.
- busy  out  1  queue not empty, or a request is in flight.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky: a commit was dropped.
- level  out  $clog2(DEPTH)+1  current entry count.

## Operation
- Staging registers: stage_data[31:0], stage_addr_lo[15:0]. All are 0 at reset.
- pi_wr_stb decode by pi_addr:
  - 0: stage_data[15:0] <= pi_wdata.
  - 1: stage_data[31:16] <= pi_wdata.
  - 2: stage_addr_lo <= pi_wdata.
  - 3: commit entry {address = {pi_wdata[7:0], stage_addr_lo}, size = pi_wdata[9:8], read = pi_wdata[10], fc = pi_wdata[13:11], data = stage_data}.
  - 5: clear overflow.
  - Other addresses are ignored.
- Staging registers keep their values after a commit. Back-to-back requests rewrite only the fields that change.
- Commit when not full, or when full with a pop in the same cycle: entry is written at the write pointer and the pointer advances.
- Commit when full with no pop: entry is dropped; overflow <= 1. It stays set until an addr-5 write or reset.
- In-flight flag:
  - set on the handshake (req_valid & req_ready);
  - cleared by done_stb;
  - done_stb while not in flight is ignored.
- req_valid = (level != 0) & ~inflight. Only one request is outstanding.
- Pop happens on the handshake. The read pointer advances and level decrements.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- rd_data <= done_rdata on done_stb, only if the popped request was a read. The direction is latched at the handshake. Write completions leave rd_data unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level runs 0..DEPTH.
- Reset (async, any time, including mid-request) clears all state:
  - pointers, level, inflight and overflow = 0;
  - rd_data and staging registers = 0;
  - outputs: req_valid = 0, busy = 0, full = 0, level = 0, req_* = 0 (head reads a cleared entry).
  - FIFO storage need not be cleared; req_* must read as 0 while level = 0.

## Timing
- Commit at edge N: level, full and busy update at N+1. req_valid rises at N+1 if not in flight.
- req_* are driven combinationally from the head entry and are stable while req_valid is high.
- Handshake at edge N: next head (or req_valid = 0) from N+1. busy stays high through in-flight.
- done_stb at edge N:
  - rd_data updates at N+1;
  - req_valid may rise again at N+1;
  - busy falls at N+1 if the queue is empty.
- Throughput is limited by the engine. Queue overhead is at most 1 cycle between done_stb and the next req_valid.
- Commit-to-req_valid latency is 1 cycle when the queue is empty and idle.

## Test plan
- Single write: addr0 = 0x1234, addr1 = 0xABCD, addr2 = 0x0004, addr3 = 0x0100 -> next cycle:
  - req_valid = 1, req_address = 0x000004, req_size = 01, req_read = 0, req_data = 0xABCD1234, busy = 1;
  - ready pulse then done_stb -> busy = 0, rd_data unchanged.
- Read completion: commit addr3 = 0x0500 (read, size 01) -> handshake, then done_stb with done_rdata = 0xDEADBEEF -> rd_data = 0xDEADBEEF one cycle later.
- Fill and overflow: with req_ready held 0, commit DEPTH+1 entries:
  - full = 1 after the DEPTH-th, level = DEPTH;
  - the extra commit is dropped and overflow = 1;
  - addr5 write -> overflow = 0.
- Ordering and wrap: commit 2*DEPTH+3 entries with distinct addresses while the engine acknowledges every 3rd cycle -> addresses pop in commit order across pointer wrap, none lost.
- Simultaneous push and pop when full: commit in the same cycle as a handshake -> entry accepted, level stays DEPTH, overflow = 0.
- Reset mid-request: assert nRESET low while in flight with 2 entries queued -> immediately req_valid = 0, busy = 0, level = 0. A later done_stb is ignored and rd_data stays 0.
